// File: rtl/spike_packet_encoder.sv
// ---------------------------------------------------------------------------
// spike_packet_encoder
//   Latches spike pulses from N_NEURONS neurons and, for each spiking neuron,
//   walks its slice of a CSR connection table. One {src,dst} packet is sent
//   per connection over a valid/ready link to the router. The address,
//   pointer and connection tables are loaded through a narrow write port.
//   ts_done reports that the node has drained everything for the timestep.
//
//   Optional feature macro: PKT_TS_TAG_EN
//     defined   -> pkt_data = {ts_tag, src, dst}, the tag being the timestep
//                  count captured when the neuron was selected
//     undefined -> pkt_data = {src, dst}
//
// Ports
//   CLK        clock, rising edge
//   RESET_N    asynchronous active-low reset
//   spike_in   per-neuron spike pulses, sampled every edge
//   ts_start   one-cycle pulse marking a new timestep
//   cfg_we     table write strobe
//   cfg_sel    00 neuron addr, 01 CSR pointer, 10 connection entry, 11 reserved
//   cfg_idx    table index
//   cfg_data   write data (pointer writes use the low PTR_W bits)
//   cfg_err    one-cycle pulse: previous write rejected
//   pkt_valid  packet valid
//   pkt_ready  router accepts packet
//   pkt_data   packet payload
//   busy       FSM active or any spike pending
//   ts_done    registered: idle, nothing pending, no spike arriving
// ---------------------------------------------------------------------------
module spike_packet_encoder #(
    parameter int N_NEURONS = 10,
    parameter int ADDR_W    = 12,
    parameter int MAX_CONN  = 32,
    parameter int PTR_W     = 6,
    parameter int IDX_W     = 6,
    parameter int TS_W      = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [N_NEURONS-1:0]   spike_in,
    input  logic                   ts_start,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_data,
    output logic                   cfg_err,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
`ifdef PKT_TS_TAG_EN
    output logic [2*ADDR_W+TS_W-1:0] pkt_data,
`else
    output logic [2*ADDR_W-1:0]      pkt_data,
`endif
    output logic                   busy,
    output logic                   ts_done
);

    localparam int NW = $clog2(N_NEURONS + 1);
    localparam int CW = $clog2(MAX_CONN);
    localparam logic [IDX_W-1:0] L_N_IDX  = IDX_W'(N_NEURONS);
    localparam logic [IDX_W-1:0] L_MC_IDX = IDX_W'(MAX_CONN);
    localparam logic [PTR_W-1:0] L_MC_PTR = PTR_W'(MAX_CONN);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr [N_NEURONS];
    logic [PTR_W-1:0]     r_ptr  [N_NEURONS+1];
    logic [ADDR_W-1:0]    r_conn [MAX_CONN];

    logic [N_NEURONS-1:0] r_pending;
    logic [NW-1:0]        r_cur;
    logic [PTR_W-1:0]     r_j;
    logic [PTR_W-1:0]     r_end;
    logic [TS_W-1:0]      r_ts_cnt;
    logic                 r_cfg_err;
    logic                 r_ts_done;
`ifdef PKT_TS_TAG_EN
    logic [TS_W-1:0]      r_tag;
`endif

    logic [NW-1:0]        w_sel;
    logic                 w_found;
    logic [N_NEURONS-1:0] w_clr;
    logic                 w_others;
    logic [PTR_W-1:0]     w_ptr_lo;
    logic [PTR_W-1:0]     w_ptr_hi;
    logic [PTR_W-1:0]     w_j_inc;
    logic                 w_last;
    logic [ADDR_W-1:0]    w_conn_q;
    logic                 w_idx_ok;
    logic                 w_cfg_ok;
    logic [TS_W-1:0]      w_ts_nxt;

    // Lowest-index pending neuron
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (r_pending[i] && !w_found) begin
                w_sel   = NW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_clr    = (r_state == S_SCAN && w_found) ? (N_NEURONS'(1) << w_sel) : '0;
    assign w_others = ((r_pending & ~w_clr) != '0);
    assign w_ptr_lo = r_ptr[w_sel];
    assign w_ptr_hi = r_ptr[w_sel + NW'(1)];
    assign w_j_inc  = r_j + PTR_W'(1);
    assign w_last   = (w_j_inc == r_end) || (w_j_inc == L_MC_PTR);
    assign w_conn_q = (r_j < L_MC_PTR) ? r_conn[r_j[CW-1:0]] : '0;
    assign w_ts_nxt = r_ts_cnt + TS_W'(ts_start);

    always_comb begin
        w_idx_ok = 1'b0;
        unique case (cfg_sel)
            2'b00:   w_idx_ok = (cfg_idx <  L_N_IDX);
            2'b01:   w_idx_ok = (cfg_idx <= L_N_IDX);
            2'b10:   w_idx_ok = (cfg_idx <  L_MC_IDX);
            default: w_idx_ok = 1'b0;
        endcase
        w_cfg_ok = w_idx_ok && (r_state == S_IDLE) && (r_pending == '0);
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and link outputs
    always_comb begin
        w_state_nxt = r_state;
        pkt_valid   = 1'b0;
        pkt_data    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending != '0) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                // Empty or malformed CSR range: serve nothing for this neuron
                if (w_ptr_hi <= w_ptr_lo) w_state_nxt = w_others ? S_SCAN : S_IDLE;
                else                      w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                pkt_valid = 1'b1;
`ifdef PKT_TS_TAG_EN
                pkt_data  = {r_tag, r_addr[r_cur], w_conn_q};
`else
                pkt_data  = {r_addr[r_cur], w_conn_q};
`endif
                // The served bit is already cleared, so r_pending holds only others
                if (pkt_ready && w_last) w_state_nxt = (r_pending != '0) ? S_SCAN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, counters and tables
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= '0;
            r_cur     <= '0;
            r_j       <= '0;
            r_end     <= '0;
            r_ts_cnt  <= '0;
            r_cfg_err <= 1'b0;
            r_ts_done <= 1'b0;
`ifdef PKT_TS_TAG_EN
            r_tag     <= '0;
`endif
            for (int unsigned i = 0; i < N_NEURONS; i++)     r_addr[i] <= '0;
            for (int unsigned i = 0; i < N_NEURONS + 1; i++) r_ptr[i]  <= '0;
            for (int unsigned i = 0; i < MAX_CONN; i++)      r_conn[i] <= '0;
        end else begin
            // A new spike on the bit being cleared survives
            r_pending <= (r_pending & ~w_clr) | spike_in;

            if (r_state == S_SCAN) begin
                r_cur <= w_sel;
                r_j   <= w_ptr_lo;
                r_end <= w_ptr_hi;
`ifdef PKT_TS_TAG_EN
                r_tag <= r_ts_cnt;
`endif
            end else if (r_state == S_EMIT && pkt_ready) begin
                r_j <= w_j_inc;
            end

            r_ts_cnt  <= w_ts_nxt;
            // Counter advancing this cycle means a timestep just started
            r_ts_done <= (r_state == S_IDLE) && (r_pending == '0) &&
                         (spike_in == '0) && (w_ts_nxt == r_ts_cnt);

            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (cfg_we && w_cfg_ok) begin
                unique case (cfg_sel)
                    2'b00:   r_addr[cfg_idx[NW-1:0]] <= cfg_data;
                    2'b01:   r_ptr[cfg_idx[NW-1:0]]  <= cfg_data[PTR_W-1:0];
                    2'b10:   r_conn[cfg_idx[CW-1:0]] <= cfg_data;
                    default: ;
                endcase
            end
        end
    end

    assign cfg_err = r_cfg_err;
    assign ts_done = r_ts_done;
    assign busy    = (r_state != S_IDLE) || (r_pending != '0);

endmodule
